regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Read-side companion to the 8x32 register file: on a Start pulse it walks a contiguous, wrapping range of register addresses through the file's read port.
- It streams each word out on a valid/ready interface, tagged with its register address.
- Used for debug dumps of architectural state and for scan-out to a host link.
- Drives the file's R_Addr, samples its combinational R_Data, and never writes.

Parameters:
- DATA_W, 32, register word width; matches R_Data.
- ADDR_W, 3, register address width; the file depth is 2^ADDR_W.

Ports:
- Clk  input  1  rising-edge clock shared with the register file.
- Rst  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- Base_Addr  input  ADDR_W  first register to read; latched on accepted Start.
- Count  input  ADDR_W+1  number of registers to dump; 0 means 2^ADDR_W; latched on accepted Start.
- R_Addr  output  ADDR_W  read address to the register file; registered.
- R_Data  input  DATA_W  combinational read data from the register file.
- Out_Data  output  DATA_W  streamed word.
- Out_Addr  output  ADDR_W  register index of Out_Data.
- Out_Is_Sum  output  1  marks a checksum word (see Optional Feature).
- Out_Valid  output  1  Out_* fields hold a word.
- Out_Ready  input  1  sink accepts the word on a rising edge where Out_Valid=1 and Out_Ready=1.
- Busy  output  1  high from accepted Start until Done.
- Done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; R_Addr=0, Out_Data=0, Out_Addr=0, Out_Is_Sum=0, Out_Valid=0, Busy=0, Done=0, remaining count=0.
- Reset mid-dump aborts immediately. No Done is produced, and no partial word stays valid.
- IDLE: if Start=1 at a clock edge:
  - R_Addr <= Base_Addr.
  - remaining <= (Count==0 ? 2^ADDR_W : Count).
  - Busy <= 1; go to FETCH.
- FETCH (exactly one cycle):
  - Out_Data <= R_Data, Out_Addr <= R_Addr, Out_Valid <= 1; go to SEND.
- SEND: Out_Data, Out_Addr and Out_Valid hold stable while Out_Ready=0; the sink may stall indefinitely. On handshake:
  - If remaining==1, go to DONE, or to SUM when the checksum is enabled.
  - Otherwise, remaining <= remaining-1, R_Addr <= R_Addr+1 (mod 2^ADDR_W, so 7 wraps to 0), Out_Valid <= 0; go to FETCH.
- DONE (one cycle): Out_Valid=0, Done=1, Busy <= 0; go to IDLE.
- Latency: with Start accepted at edge N, R_Addr is valid after N and the first Out_Valid=1 after N+1. With Out_Ready held high, throughput is one word per 2 cycles.
- Start while Busy=1 is ignored and not queued. Start in the DONE cycle is also ignored.
- Base_Addr and Count changes after acceptance have no effect on the running dump.
- Out_Valid never drops without a handshake, except on reset.
- The register file may be written during a dump. Each word reflects R_Data at its FETCH cycle.

Optional Feature:
- Macro REGFILE_DUMP_CHECKSUM_EN.
- When defined:
  - A DATA_W accumulator clears on accepted Start and adds each data word as it is captured in FETCH, sum mod 2^DATA_W.
  - After the last data handshake the FSM enters SUM and presents Out_Data=sum, Out_Addr=0, Out_Is_Sum=1, Out_Valid=1 under the same hold rules.
  - On its handshake the FSM goes to DONE.
  - Out_Is_Sum is 0 for every data word.
- When undefined: no SUM state and no accumulator; Out_Is_Sum is tied to 0.

Test Plan:
1. Preload regs 0..7 = {1,0,321,111,0,666,0,0}. Start, Base=2, Count=3, Out_Ready=1 → three words (2,321),(3,111),(4,0), each 2 cycles apart; then a Done pulse; Busy low next cycle.
2. Base=6, Count=4, Out_Ready=1 → addresses 6,7,0,1 with data 0,0,1,0, confirming wrap-around.
3. Count=0, Base=0 → 8 words, addresses 0..7 in order; Done after the 8th handshake.
4. Out_Ready held low 5 cycles on the first word → Out_Data=321, Out_Addr=2, Out_Valid=1 stay stable the whole time. A Start pulse during the stall is ignored; the dump completes with the original range.
5. Assert Rst=0 asynchronously mid-SEND → all outputs go to reset values immediately with no Done. After release, a new Start dumps correctly.
6. With REGFILE_DUMP_CHECKSUM_EN: Base=2, Count=4 → data words 321,111,0,666, then a checksum word Out_Data=1098, Out_Is_Sum=1, then Done.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping address range through a register file read port and streams each word
// out on a valid/ready interface. Define REGFILE_DUMP_CHECKSUM_EN to append a checksum word.
module regfile_dump_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_Addr,
  input  logic [ADDR_W:0]   Count,
  output logic [ADDR_W-1:0] R_Addr,
  input  logic [DATA_W-1:0] R_Data,
  output logic [DATA_W-1:0] Out_Data,
  output logic [ADDR_W-1:0] Out_Addr,
  output logic              Out_Is_Sum,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {StIdle, StFetch, StSend, StSum, StDone} state_e;

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] OneLeft   = (ADDR_W + 1)'(1);

  state_e          state;
  logic [ADDR_W:0] remaining;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`else
  assign Out_Is_Sum = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= StIdle;
      remaining <= '0;
      R_Addr    <= '0;
      Out_Data  <= '0;
      Out_Addr  <= '0;
      Out_Valid <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      Out_Is_Sum <= 1'b0;
      sum        <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (Start) begin
            R_Addr    <= Base_Addr;
            remaining <= (Count == '0) ? FullCount : Count;
            Busy      <= 1'b1;
            state     <= StFetch;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
          end
        end
        StFetch: begin
          Out_Data  <= R_Data;
          Out_Addr  <= R_Addr;
          Out_Valid <= 1'b1;
          state     <= StSend;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          sum       <= sum + R_Data;
`endif
        end
        StSend: begin
          if (Out_Ready) begin
            if (remaining == OneLeft) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              // sum already includes the last word, captured in its FETCH cycle
              Out_Data   <= sum;
              Out_Addr   <= '0;
              Out_Is_Sum <= 1'b1;
              state      <= StSum;
`else
              Out_Valid <= 1'b0;
              Done      <= 1'b1;
              state     <= StDone;
`endif
            end else begin
              remaining <= remaining - OneLeft;
              R_Addr    <= R_Addr + 1'b1;
              Out_Valid <= 1'b0;
              state     <= StFetch;
            end
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        StSum: begin
          if (Out_Ready) begin
            Out_Valid  <= 1'b0;
            Out_Is_Sum <= 1'b0;
            Done       <= 1'b1;
            state      <= StDone;
          end
        end
`endif
        StDone: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
